// File: rtl/frv_core_fetch_req_pkg.sv
// Shared widths and helpers for the instruction-fetch request engine.
package frv_core_fetch_req_pkg;

    localparam int XL      = 32;   // architectural register / PC width
    localparam int IMEM_AW = 32;   // imem address width
    localparam int IMEM_DW = 32;   // imem data width

    // Address of the next aligned word after the given word index.
    function automatic logic [XL-1:1] next_word(input logic [XL-1:2] word);
        next_word = {word + 30'd1, 1'b0};
    endfunction

endpackage

// File: rtl/frv_core_fetch_req.sv
// Instruction-fetch request/response engine: issues word-aligned imem
// requests, counts outstanding transactions, and forwards responses to the
// fetch buffer. A redirect flushes the buffer and drops stale responses.
module frv_core_fetch_req
    import frv_core_fetch_req_pkg::*;
#(
    parameter logic [XL-1:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
    parameter int            MAX_OUT            = 2
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               cf_req,
    input  logic [XL-1:0]      cf_target,
    output logic               cf_ack,
    output logic               buf_flush,
    output logic               imem_req,
    input  logic               imem_gnt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_recv,
    output logic               imem_ack,
    input  logic               imem_error,
    input  logic [IMEM_DW-1:0] imem_rdata,
    output logic               f_4byte,
    output logic               f_2byte,
    output logic               f_err,
    output logic [IMEM_DW-1:0] f_in,
    input  logic               f_ready
);

    localparam int            CW        = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    logic [XL-1:1] fetch_pc;
    logic          req_hold;
    logic [CW-1:0] n_out;
    logic [CW-1:0] n_drop;
    logic          first_half;

    logic          redirect;
    logic          dropping;
    logic          grant;
    logic          rsp_done;
    logic          push;

    // Bit 0 of the target is meaningless for 2-byte-aligned fetch, and
    // fetch_pc[1] only matters through first_half, never the address.
    logic [1:0]    unused_bits;
    assign unused_bits = {cf_target[0], fetch_pc[1]};

    // Request side. An ungranted request must stay put, so it blocks redirects.
    assign cf_ack    = g_resetn & ~req_hold;
    assign redirect  = cf_req & cf_ack;
    assign buf_flush = redirect;
    assign imem_req  = g_resetn & (req_hold | (~cf_req & (n_out < MAX_OUT_C)));
    assign imem_addr = g_resetn ? {fetch_pc[XL-1:2], 2'b00} : '0;
    assign grant     = imem_req & imem_gnt;

    // Response side. Stale responses (redirect cycle or pending drops) are
    // acked unconditionally and never reach the buffer.
    assign dropping  = redirect | (n_drop != '0);
    assign imem_ack  = g_resetn & imem_recv & (dropping | f_ready);
    assign rsp_done  = imem_recv & imem_ack;
    assign push      = g_resetn & imem_recv & f_ready & ~dropping;
    assign f_4byte   = push & ~first_half;
    assign f_2byte   = push & first_half;
    assign f_err     = push & imem_error;
    assign f_in      = g_resetn ? imem_rdata : '0;

    // Fetch PC, request hold, outstanding/drop counters and half-word flag.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            fetch_pc   <= FRV_PC_RESET_VALUE[XL-1:1];
            req_hold   <= 1'b0;
            n_out      <= '0;
            n_drop     <= '0;
            first_half <= FRV_PC_RESET_VALUE[1];
        end else begin
            req_hold <= imem_req & ~imem_gnt;
            n_out    <= n_out + CW'(grant) - CW'(rsp_done);

            if (redirect) begin
                fetch_pc <= cf_target[XL-1:1];
            end else if (grant) begin
                fetch_pc <= next_word(fetch_pc[XL-1:2]);
            end

            if (redirect) begin
                first_half <= cf_target[1];
            end else if (push) begin
                first_half <= 1'b0;
            end

            if (redirect) begin
                n_drop <= n_out - CW'(rsp_done);
            end else if ((n_drop != '0) && rsp_done) begin
                n_drop <= n_drop - CW'(1);
            end
        end
    end

    // A response with nothing outstanding means the memory broke protocol.
    always_ff @(posedge g_clk) begin
        if (g_resetn && imem_recv) begin
            assert (n_out != '0);
        end
    end

endmodule

// File: tb/tb_frv_core_fetch_req.sv
// Directed bench for frv_core_fetch_req: a bench-side memory answers one
// cycle after grant from a scoreboard of granted transactions, and every
// cycle checks request, redirect and push behaviour against a small model.
module tb_frv_core_fetch_req;

    localparam logic [31:0] RST = 32'h8000_0000;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cf_req;
    logic [31:0] cf_target;
    logic        cf_ack;
    logic        buf_flush;
    logic        imem_req;
    logic        imem_gnt;
    logic [31:0] imem_addr;
    logic        imem_recv;
    logic        imem_ack;
    logic        imem_error;
    logic [31:0] imem_rdata;
    logic        f_4byte;
    logic        f_2byte;
    logic        f_err;
    logic [31:0] f_in;
    logic        f_ready;

    frv_core_fetch_req #(.FRV_PC_RESET_VALUE(RST), .MAX_OUT(2)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cf_req(cf_req), .cf_target(cf_target), .cf_ack(cf_ack),
        .buf_flush(buf_flush),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .f_4byte(f_4byte), .f_2byte(f_2byte), .f_err(f_err), .f_in(f_in),
        .f_ready(f_ready)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic        drop;
    } txn_t;

    txn_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        gnt_en, mem_en;
    logic [31:0] err_addr;
    logic [31:0] m_pc;
    logic        m_hold, m_first;
    int          n_err_push, n_half_push;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        data_of = a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory side, check at mid-cycle, advance the model.
    task automatic cycle();
        txn_t        f;
        logic        recv, redir, exp_req, exp_iack, push;
        logic [31:0] a;
        recv = g_resetn && mem_en && (sb.size() > 0);
        if (recv) f = sb[0];
        else      f = '{addr: 32'h0, data: 32'h0, err: 1'b0, drop: 1'b0};
        imem_recv  = recv;
        imem_rdata = recv ? f.data : 32'h0;
        imem_error = recv & f.err;
        imem_gnt   = gnt_en;
        #4;
        if (!g_resetn) begin
            chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
            chk("rst_imem_addr", imem_addr, 32'h0);
            chk("rst_cf_ack", {31'b0, cf_ack}, 32'h0);
            chk("rst_buf_flush", {31'b0, buf_flush}, 32'h0);
            chk("rst_imem_ack", {31'b0, imem_ack}, 32'h0);
            chk("rst_f_push", {29'b0, f_4byte, f_2byte, f_err}, 32'h0);
            chk("rst_f_in", f_in, 32'h0);
            sb.delete();
            m_pc    = RST;
            m_hold  = 1'b0;
            m_first = RST[1];
        end else begin
            redir   = cf_req & ~m_hold;
            exp_req = m_hold | (~cf_req & (sb.size() < 2));
            chk("cf_ack", {31'b0, cf_ack}, {31'b0, ~m_hold});
            chk("buf_flush", {31'b0, buf_flush}, {31'b0, redir});
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
            if (redir) begin
                foreach (sb[i]) sb[i].drop = 1'b1;
                f.drop = 1'b1;
            end
            exp_iack = recv & (f.drop | f_ready);
            push     = recv & ~f.drop & f_ready;
            chk("imem_ack", {31'b0, imem_ack}, {31'b0, exp_iack});
            chk("f_4byte", {31'b0, f_4byte}, {31'b0, push & ~m_first});
            chk("f_2byte", {31'b0, f_2byte}, {31'b0, push & m_first});
            chk("f_err", {31'b0, f_err}, {31'b0, push & f.err});
            if (push) begin
                chk("f_in", f_in, f.data);
                if (f.err)   n_err_push++;
                if (m_first) n_half_push++;
                m_first = 1'b0;
            end
            if (exp_iack) void'(sb.pop_front());
            if (redir) begin
                m_pc    = cf_target & 32'hFFFF_FFFE;
                m_first = cf_target[1];
            end else if (exp_req && gnt_en) begin
                a = m_pc & 32'hFFFF_FFFC;
                sb.push_back('{addr: a, data: data_of(a), err: (a == err_addr), drop: 1'b0});
                m_pc = a + 32'd4;
            end
            m_hold = exp_req & ~gnt_en;
        end
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn   = 1'b0;
        cf_req     = 1'b0;
        cf_target  = 32'h0;
        gnt_en     = 1'b1;
        mem_en     = 1'b1;
        f_ready    = 1'b1;
        err_addr   = 32'hFFFF_FFFF;
        imem_gnt   = 1'b0;
        imem_recv  = 1'b0;
        imem_error = 1'b0;
        imem_rdata = 32'h0;
        m_pc       = RST;
        m_hold     = 1'b0;
        m_first    = RST[1];
        n_err_push  = 0;
        n_half_push = 0;

        // reset state
        repeat (2) cycle();
        // streaming fetch from the reset PC
        g_resetn = 1'b1;
        repeat (8) cycle();
        // redirect to a half-word target with a response in flight
        cf_req = 1'b1; cf_target = 32'h8000_0102;
        cycle();
        cf_req = 1'b0;
        repeat (4) cycle();
        chk("half_push_seen", n_half_push, 1);
        // two outstanding, redirect, both dropped, then target data
        mem_en = 1'b0;
        repeat (2) cycle();
        cf_req = 1'b1; cf_target = 32'h8000_0200;
        cycle();
        cf_req = 1'b0; mem_en = 1'b1;
        repeat (5) cycle();
        // ungranted request blocks a redirect until granted
        gnt_en = 1'b0;
        cycle();
        cf_req = 1'b1; cf_target = 32'h8000_0300;
        repeat (3) cycle();
        gnt_en = 1'b1;
        cycle();
        cycle();
        cf_req = 1'b0;
        repeat (4) cycle();
        // buffer back-pressure
        f_ready = 1'b0;
        repeat (3) cycle();
        f_ready = 1'b1;
        repeat (3) cycle();
        // bus error on an upcoming word; fetch carries on
        err_addr = (m_pc & 32'hFFFF_FFFC) + 32'd8;
        repeat (5) cycle();
        chk("err_push_seen", n_err_push, 1);
        // reset in the middle of a drop phase
        mem_en = 1'b0;
        repeat (2) cycle();
        cf_req = 1'b1; cf_target = 32'h8000_0400;
        cycle();
        cf_req = 1'b0; mem_en = 1'b1;
        cycle();
        g_resetn = 1'b0;
        cycle();
        g_resetn = 1'b1;
        repeat (6) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
